// File: rtl/alu_lockstep_array.sv
// alu_lockstep_array
//
// N-channel ALU array with lockstep cross-check, majority vote and a fault latch.
// Every channel runs a WIDTH-bit unsigned op on its own operands. In lockstep mode each
// channel's {result, carry} is compared against channel 0; mismatching sets bump a
// saturating counter and, once the counter reaches ERR_THRESH, the block enters FAULT and
// freezes all outputs until clr_err_i.
//
// Ports
//   wb_clk_i      in   1          clock, rising edge
//   wb_rst_i      in   1          synchronous reset, active-high
//   in_valid_i    in   1          operand set valid this cycle
//   mode_i        in   1          0 = independent, 1 = lockstep compare
//   a_i, b_i      in   NCH*WIDTH  channel k operand = x[k*WIDTH +: WIDTH]
//   sel_i         in   NCH*2      channel k op = sel_i[2k +: 2] (00 add, 01 sub, 10 and, 11 xor)
//   clr_err_i     in   1          clear counter, sticky flag and FAULT
//   out_valid_o   out  1          one-cycle pulse per accepted set
//   alu_out_o     out  NCH*WIDTH  registered per-channel results
//   carry_o       out  NCH        registered per-channel carry/borrow
//   diff_o        out  WIDTH      ch0 result ^ ch1 result
//   carry_diff_o  out  1          carry_o[0] ^ carry_o[1]
//   voted_o       out  WIDTH      bitwise majority (NCH=3) or ch0 result (NCH=2)
//   mismatch_o    out  1          lockstep mismatch on current output set
//   err_sticky_o  out  1          set by any counted mismatch, held until clear
//   err_cnt_o     out  ERR_CNT_W  saturating mismatch count
//   fault_o       out  1          high in FAULT state

module alu_lockstep_array #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NCH        = 2,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned ERR_THRESH = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   in_valid_i,
    input  logic                   mode_i,
    input  logic [NCH*WIDTH-1:0]   a_i,
    input  logic [NCH*WIDTH-1:0]   b_i,
    input  logic [NCH*2-1:0]       sel_i,
    input  logic                   clr_err_i,
    output logic                   out_valid_o,
    output logic [NCH*WIDTH-1:0]   alu_out_o,
    output logic [NCH-1:0]         carry_o,
    output logic [WIDTH-1:0]       diff_o,
    output logic                   carry_diff_o,
    output logic [WIDTH-1:0]       voted_o,
    output logic                   mismatch_o,
    output logic                   err_sticky_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    output logic                   fault_o
);

    localparam logic [ERR_CNT_W-1:0] CntMax    = '1;
    localparam logic [ERR_CNT_W-1:0] CntThresh = ERR_CNT_W'(ERR_THRESH);
    localparam logic [ERR_CNT_W-1:0] CntOne    = ERR_CNT_W'(1);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e state_q, state_d;

    // Combinational results of the set currently on the inputs
    logic [NCH*WIDTH-1:0] alu_d;
    logic [NCH-1:0]       carry_d;
    logic [WIDTH-1:0]     diff_d;
    logic [WIDTH-1:0]     voted_d;
    logic                 mismatch_d;

    // Registered outputs
    logic                 out_valid_q;
    logic [NCH*WIDTH-1:0] alu_q;
    logic [NCH-1:0]       carry_q;
    logic [WIDTH-1:0]     diff_q;
    logic [WIDTH-1:0]     voted_q;
    logic                 mismatch_q;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 accept;
    logic                 count_inc;
    logic [ERR_CNT_W-1:0] cnt_inc_val;

    // ------------------------------------------------------------------
    // Per-channel ALU. The extra MSB of res carries the add carry-out, or the
    // borrow for subtraction (zero-extended A-B wraps above 2^WIDTH iff A<B).
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [1:0]       op_sel;
        logic [WIDTH:0]   res;

        assign op_a   = a_i[k*WIDTH +: WIDTH];
        assign op_b   = b_i[k*WIDTH +: WIDTH];
        assign op_sel = sel_i[2*k +: 2];

        always_comb begin
            res = '0;
            unique case (op_sel)
                2'b00: res = {1'b0, op_a} + {1'b0, op_b};
                2'b01: res = {1'b0, op_a} - {1'b0, op_b};
                2'b10: res = {1'b0, op_a & op_b};
                2'b11: res = {1'b0, op_a ^ op_b};
                default: res = '0;
            endcase
        end

        assign alu_d[k*WIDTH +: WIDTH] = res[WIDTH-1:0];
        assign carry_d[k]              = res[WIDTH];
    end

    assign diff_d = alu_d[WIDTH-1:0] ^ alu_d[2*WIDTH-1:WIDTH];

    if (NCH == 3) begin : g_vote3
        logic [WIDTH-1:0] r0, r1, r2;
        assign r0      = alu_d[WIDTH-1:0];
        assign r1      = alu_d[2*WIDTH-1:WIDTH];
        assign r2      = alu_d[3*WIDTH-1:2*WIDTH];
        assign voted_d = (r0 & r1) | (r0 & r2) | (r1 & r2);
    end else begin : g_vote2
        assign voted_d = alu_d[WIDTH-1:0];
    end

    // Lockstep compare of {result, carry} of every channel against channel 0
    always_comb begin
        mismatch_d = 1'b0;
        for (int k = 1; k < NCH; k++) begin
            if ({alu_d[k*WIDTH +: WIDTH], carry_d[k]} != {alu_d[WIDTH-1:0], carry_d[0]}) begin
                mismatch_d = 1'b1;
            end
        end
        mismatch_d = mismatch_d & mode_i;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (count_inc && (cnt_inc_val == CntThresh)) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                if (clr_err_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        accept  = 1'b0;
        fault_o = 1'b0;
        unique case (state_q)
            StRun:   accept  = in_valid_i;
            StFault: fault_o = 1'b1;
            default: ;
        endcase
    end

    // A coincident clear wins over counting the mismatch of the same set
    assign count_inc   = accept && mismatch_d && !clr_err_i;
    assign cnt_inc_val = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + CntOne;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err_i) begin
            err_cnt_d = '0;
        end else if (count_inc) begin
            err_cnt_d = cnt_inc_val;
        end
    end

    // ------------------------------------------------------------------
    // Result and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_valid_q  <= 1'b0;
            alu_q        <= '0;
            carry_q      <= '0;
            diff_q       <= '0;
            voted_q      <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                alu_q      <= alu_d;
                carry_q    <= carry_d;
                diff_q     <= diff_d;
                voted_q    <= voted_d;
                mismatch_q <= mismatch_d;
            end
            if (clr_err_i) begin
                err_sticky_q <= 1'b0;
            end else if (count_inc) begin
                err_sticky_q <= 1'b1;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign alu_out_o    = alu_q;
    assign carry_o      = carry_q;
    assign diff_o       = diff_q;
    assign carry_diff_o = carry_q[0] ^ carry_q[1];
    assign voted_o      = voted_q;
    assign mismatch_o   = mismatch_q;
    assign err_sticky_o = err_sticky_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
